rgb2gray_stream: RTL

//  Parametrised, pipelined RGB-to-grayscale converter with valid/ready flow control.
//  It converts one pixel per cycle using a runtime-selectable weighting mode
//  (BT.601, BT.709, average, max).
//  It sits between the pixel source (memory reader / camera front end) and the

---
 rtl/rgb2gray_pkg.sv | 47 ++++
 rtl/rgb2gray_mac.sv | 58 +++++
 rtl/rgb2gray_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the RGB-to-gray streaming converter.
// Weights are 8-bit fractions that sum to 256 for every weighted mode.
package rgb2gray_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ROUND     = 128;

    typedef enum logic [1:0] {
        MODE_601 = 2'd0,
        MODE_709 = 2'd1,
        MODE_AVG = 2'd2,
        MODE_MAX = 2'd3
    } mode_e;

    typedef struct packed {
        logic [FRAC_BITS-1:0] cr;
        logic [FRAC_BITS-1:0] cg;
        logic [FRAC_BITS-1:0] cb;
    } coef_t;

    localparam logic [FRAC_BITS-1:0] C601_R = 8'd77;
    localparam logic [FRAC_BITS-1:0] C601_G = 8'd150;
    localparam logic [FRAC_BITS-1:0] C601_B = 8'd29;

    localparam logic [FRAC_BITS-1:0] C709_R = 8'd54;
    localparam logic [FRAC_BITS-1:0] C709_G = 8'd183;
    localparam logic [FRAC_BITS-1:0] C709_B = 8'd19;

    localparam logic [FRAC_BITS-1:0] CAVG_R = 8'd85;
    localparam logic [FRAC_BITS-1:0] CAVG_G = 8'd86;
    localparam logic [FRAC_BITS-1:0] CAVG_B = 8'd85;

    // Max mode bypasses the MAC, so its weights are simply zero.
    function automatic coef_t coef_sel(input mode_e m);
        coef_t c;
        c = '0;
        unique case (m)
            MODE_601: c = '{cr: C601_R, cg: C601_G, cb: C601_B};
            MODE_709: c = '{cr: C709_R, cg: C709_G, cb: C709_B};
            MODE_AVG: c = '{cr: CAVG_R, cg: CAVG_G, cb: CAVG_B};
            MODE_MAX: c = '0;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb2gray_mac.sv
// Weighted-sum datapath: products registered at S2, rounded and
// saturated sum registered at S3. Both registers advance only on en.
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    input  mode_e         mode,
    output logic [DW-1:0] gray
);

    localparam int PW = DW + FRAC_BITS;
    localparam int SW = DW + 10;

    coef_t         c;
    logic [PW-1:0] p_r;
    logic [PW-1:0] p_g;
    logic [PW-1:0] p_b;
    logic [SW-1:0] sum;
    logic [DW+1:0] q;
    logic [DW-1:0] sat;

    assign c = coef_sel(mode);

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
        end else if (en) begin
            p_r <= {{FRAC_BITS{1'b0}}, r} * {{DW{1'b0}}, c.cr};
            p_g <= {{FRAC_BITS{1'b0}}, g} * {{DW{1'b0}}, c.cg};
            p_b <= {{FRAC_BITS{1'b0}}, b} * {{DW{1'b0}}, c.cb};
        end
    end

    assign sum = {2'b00, p_r} + {2'b00, p_g} + {2'b00, p_b}
               + SW'(ROUND);
    assign q   = sum[SW-1:FRAC_BITS];

    // Any bit above the gray range means clamp to full scale.
    assign sat = (q[DW+1:DW] != 2'b00) ? {DW{1'b1}} : q[DW-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            gray <= '0;
        end else if (en) begin
            gray <= sat;
        end
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// Three-stage RGB-to-gray converter with valid/ready flow control,
// last-pixel sideband and a per-frame output pixel counter.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DW-1:0]    red_i,
    input  logic [DW-1:0]    green_i,
    input  logic [DW-1:0]    blue_i,
    input  logic             last_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DW-1:0]    gray_o,
    output logic             last_o,
    output logic [CNT_W-1:0] pix_cnt_o
);

    logic          en;

    logic          s1_valid;
    logic          s1_last;
    mode_e         s1_mode;
    logic [DW-1:0] s1_r;
    logic [DW-1:0] s1_g;
    logic [DW-1:0] s1_b;
    logic [DW-1:0] s1_max;

    logic          s2_valid;
    logic          s2_last;
    logic          s2_is_max;
    logic [DW-1:0] s2_max;

    logic          s3_is_max;
    logic [DW-1:0] s3_max;
    logic [DW-1:0] mac_gray;

    logic          out_xfer;

    // Whole pipeline moves as one: it stalls only when the
    // output holds a pixel the sink is refusing.
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_601;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else if (en) begin
            s1_valid <= valid_i;
            s1_last  <= last_i;
            s1_mode  <= mode_e'(mode_i);
            s1_r     <= red_i;
            s1_g     <= green_i;
            s1_b     <= blue_i;
        end
    end

    always_comb begin
        s1_max = s1_r;
        if (s1_g > s1_max) s1_max = s1_g;
        if (s1_b > s1_max) s1_max = s1_b;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_is_max <= 1'b0;
            s2_max    <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_is_max <= (s1_mode == MODE_MAX);
            s2_max    <= s1_max;
        end
    end

    rgb2gray_mac #(
        .DW   (DW)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .r    (s1_r),
        .g    (s1_g),
        .b    (s1_b),
        .mode (s1_mode),
        .gray (mac_gray)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            s3_is_max <= 1'b0;
            s3_max    <= '0;
        end else if (en) begin
            valid_o   <= s2_valid;
            last_o    <= s2_last;
            s3_is_max <= s2_is_max;
            s3_max    <= s2_max;
        end
    end

    // Both mux inputs reset to zero, so gray_o reads 0 out of reset.
    assign gray_o = s3_is_max ? s3_max : mac_gray;

    assign out_xfer = valid_o & ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_cnt_o <= '0;
        end else if (out_xfer) begin
            if (last_o) begin
                pix_cnt_o <= '0;
            end else if (pix_cnt_o != {CNT_W{1'b1}}) begin
                pix_cnt_o <= pix_cnt_o + 1'b1;
            end
        end
    end

endmodule
